trigger_conditioner: RTL and testbench

Input-conditioning stage that sits directly upstream of the reaction-time benchmark core. It takes the two raw push-button levels (start and user) and brings each into the clock domain with a synchronizer. Each input is then debounced with a stability counter and converted into a single-cycle rising-edge pulse that drives the core's start_trigger and user_trigger inputs. Debounced levels are also exported for status LEDs.

---
 rtl/trigger_conditioner_if.sv | 29 ++
 rtl/trigger_conditioner.sv | 57 +++++
 tb/tb_trigger_conditioner.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/trigger_conditioner_if.sv
// Button-side signal bundle for the trigger conditioner: raw push-button levels in,
// debounced levels and one-cycle press pulses out.
`timescale 1ns/1ps
interface trigger_conditioner_if;
  logic btn_start_raw;
  logic btn_user_raw;
  logic start_trigger;
  logic user_trigger;
  logic start_level;
  logic user_level;

  modport master (
    output btn_start_raw,
    output btn_user_raw,
    input  start_trigger,
    input  user_trigger,
    input  start_level,
    input  user_level
  );

  modport slave (
    input  btn_start_raw,
    input  btn_user_raw,
    output start_trigger,
    output user_trigger,
    output start_level,
    output user_level
  );
endinterface

// File: rtl/trigger_conditioner.sv
// Two independent button channels: synchronizer chain, stability-counter debounce,
// and a one-cycle pulse on each debounced 0->1 transition.
`timescale 1ns/1ps
module trigger_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500,
  parameter int SYNC_STAGES     = 2,
  parameter int CNT_W           = 16
) (
  input logic                  clk,
  input logic                  rst,
  trigger_conditioner_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int               CH_START = 0;
  localparam int               CH_USER  = 1;

  logic [1:0]                  raw;
  logic [1:0][SYNC_STAGES-1:0] sync_q;
  logic [1:0][CNT_W-1:0]       cnt_q;
  logic [1:0]                  level_q;
  logic [1:0]                  trig_q;

  assign raw[CH_START] = bus.btn_start_raw;
  assign raw[CH_USER]  = bus.btn_user_raw;

  // Level only flips after s has disagreed with it for DEBOUNCE_CYCLES straight edges;
  // the pulse fires on that same edge when the new level is 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= '0;
      trig_q  <= '0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        sync_q[ch] <= {sync_q[ch][SYNC_STAGES-2:0], raw[ch]};
        trig_q[ch] <= 1'b0;
        if (sync_q[ch][SYNC_STAGES-1] == level_q[ch]) begin
          cnt_q[ch] <= '0;
        end else if (cnt_q[ch] == CNT_LAST) begin
          level_q[ch] <= sync_q[ch][SYNC_STAGES-1];
          trig_q[ch]  <= sync_q[ch][SYNC_STAGES-1];
          cnt_q[ch]   <= '0;
        end else begin
          cnt_q[ch] <= cnt_q[ch] + 1'b1;
        end
      end
    end
  end

  assign bus.start_trigger = trig_q[CH_START];
  assign bus.user_trigger  = trig_q[CH_USER];
  assign bus.start_level   = level_q[CH_START];
  assign bus.user_level    = level_q[CH_USER];

endmodule

// File: tb/tb_trigger_conditioner.sv
// Self-checking bench for trigger_conditioner (DEBOUNCE_CYCLES=4, SYNC_STAGES=2) using a
// window-based reference model plus fixed-latency scenario checks.
`timescale 1ns/1ps
module tb_trigger_conditioner;
  localparam int DC   = 4;
  localparam int SS   = 2;
  localparam int LAT  = SS + DC - 1;
  localparam int HLEN = 8192;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  trigger_conditioner_if bus ();

  trigger_conditioner #(
    .DEBOUNCE_CYCLES(DC),
    .SYNC_STAGES    (SS),
    .CNT_W          (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference: level flips at an edge when every synchronized sample in the last DC
  // edges (since reset or the previous flip) disagrees with it; s lags raw by SS edges.
  int hist [2][HLEN];
  int n;
  int since [2];
  bit m_level [2];
  bit m_trig [2];

  always @(posedge clk) begin
    if (rst) begin
      n = 0;
      for (int ch = 0; ch < 2; ch++) begin
        since[ch]   = 0;
        m_level[ch] = 1'b0;
        m_trig[ch]  = 1'b0;
      end
    end else begin
      hist[0][n % HLEN] = int'(bus.btn_start_raw);
      hist[1][n % HLEN] = int'(bus.btn_user_raw);
      for (int ch = 0; ch < 2; ch++) begin
        bit all_diff;
        all_diff   = (n - since[ch] + 1 >= DC);
        m_trig[ch] = 1'b0;
        for (int j = n - DC + 1; j <= n; j++) begin
          if (all_diff) begin
            int sv;
            sv = (j - SS >= 0) ? hist[ch][(j - SS) % HLEN] : 0;
            if (sv == int'(m_level[ch])) all_diff = 1'b0;
          end
        end
        if (all_diff) begin
          m_trig[ch]  = ~m_level[ch];
          m_level[ch] = ~m_level[ch];
          since[ch]   = n + 1;
        end
      end
      n++;
    end
  end

  function automatic logic [3:0] dut_vec();
    return {bus.start_trigger, bus.user_trigger, bus.start_level, bus.user_level};
  endfunction

  function automatic logic [3:0] model_vec();
    return {m_trig[0], m_trig[1], m_level[0], m_level[1]};
  endfunction

  task automatic tick(input bit s, input bit u);
    bus.btn_start_raw = s;
    bus.btn_user_raw  = u;
    @(posedge clk);
    #1;
  endtask

  task automatic applyRelease(input int cycles);
    for (int k = 0; k < cycles; k++) tick(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    int pulses = 0;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 1'b1);
      total++;
      if (dut_vec() !== 4'b0000) begin
        bad++;
        $display("[TB] FAIL reset_hold cyc=%0d got=%b want=0000", k, dut_vec());
      end
    end
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(1'b1, 1'b1);
      if (bus.start_trigger === 1'b1) pulses++;
      total++;
      if (bus.start_trigger !== (k == LAT)) begin
        bad++;
        $display("[TB] FAIL reset_release_trig k=%0d got=%b want=%b", k, bus.start_trigger, (k == LAT));
      end
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++;
        $display("[TB] FAIL reset_model k=%0d got=%b want=%b", k, dut_vec(), model_vec());
      end
    end
    total++;
    if (pulses != 1 || bus.start_level !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_after pulses=%0d level=%b want pulses=1 level=1", pulses, bus.start_level);
    end
    applyRelease(12);
  endtask

  task automatic test_clean_press();
    for (int k = 0; k < 20; k++) begin
      tick(1'b0, 1'b1);
      total++;
      if ({bus.user_trigger, bus.user_level} !== {(k == LAT), (k >= LAT)}) begin
        bad++;
        $display("[TB] FAIL press_user k=%0d got=%b%b want=%b%b", k, bus.user_trigger, bus.user_level, (k == LAT), (k >= LAT));
      end
    end
    for (int k = 0; k < 12; k++) begin
      tick(1'b0, 1'b0);
      total++;
      if ({bus.user_trigger, bus.user_level} !== {1'b0, (k < LAT)}) begin
        bad++;
        $display("[TB] FAIL release_user k=%0d got=%b%b want=0%b", k, bus.user_trigger, bus.user_level, (k < LAT));
      end
    end
  endtask

  task automatic test_bounce_reject();
    bit [7:0] pat = 8'b0111_0111;
    for (int k = 0; k < 18; k++) begin
      tick((k < 8) ? pat[k] : 1'b0, 1'b0);
      total++;
      if ({bus.start_trigger, bus.start_level} !== 2'b00 || dut_vec() !== model_vec()) begin
        bad++;
        $display("[TB] FAIL bounce_reject k=%0d got=%b want=%b (start bits 00)", k, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_bounce_settle();
    int pulses = 0;
    for (int k = 0; k < 20; k++) begin
      tick((k >= 6) ? 1'b1 : ((k % 2) == 0), 1'b0);
      if (bus.start_trigger === 1'b1) pulses++;
      total++;
      if (bus.start_trigger !== (k == 6 + LAT)) begin
        bad++;
        $display("[TB] FAIL bounce_settle k=%0d got=%b want=%b", k, bus.start_trigger, (k == 6 + LAT));
      end
    end
    total++;
    if (pulses != 1) begin
      bad++;
      $display("[TB] FAIL bounce_settle_count got=%0d want=1", pulses);
    end
    applyRelease(12);
  endtask

  task automatic test_simultaneous();
    for (int k = 0; k < 12; k++) begin
      tick(1'b1, 1'b1);
      total++;
      if ({bus.start_trigger, bus.user_trigger} !== {2{(k == LAT)}}) begin
        bad++;
        $display("[TB] FAIL simultaneous k=%0d got=%b%b want=%b%b", k, bus.start_trigger, bus.user_trigger, (k == LAT), (k == LAT));
      end
    end
    applyRelease(12);
  endtask

  task automatic test_reset_mid_count();
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, 1'b1);
      total++;
      if (bus.user_trigger !== 1'b0 || bus.user_level !== 1'b0) begin
        bad++;
        $display("[TB] FAIL midcount_pre k=%0d got=%b%b want=00", k, bus.user_trigger, bus.user_level);
      end
    end
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick(1'b0, 1'b1);
      total++;
      if (dut_vec() !== 4'b0000) begin
        bad++;
        $display("[TB] FAIL midcount_rst k=%0d got=%b want=0000", k, dut_vec());
      end
    end
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(1'b0, 1'b1);
      total++;
      if (bus.user_trigger !== (k == LAT) || dut_vec() !== model_vec()) begin
        bad++;
        $display("[TB] FAIL midcount_post k=%0d got=%b want=%b", k, dut_vec(), model_vec());
      end
    end
    applyRelease(12);
  endtask

  task automatic test_random();
    bit s = 1'b0;
    bit u = 1'b0;
    int hold_s = 0;
    int hold_u = 0;
    int errs = 0;
    for (int k = 0; k < 400; k++) begin
      if (hold_s == 0) begin s = 1'($urandom_range(0, 1)); hold_s = $urandom_range(1, 8); end
      if (hold_u == 0) begin u = 1'($urandom_range(0, 1)); hold_u = $urandom_range(1, 8); end
      hold_s--;
      hold_u--;
      tick(s, u);
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++;
        errs++;
        if (errs <= 10) $display("[TB] FAIL random k=%0d got=%b want=%b", k, dut_vec(), model_vec());
      end
    end
    applyRelease(12);
  endtask

  initial begin
    bus.btn_start_raw = 1'b0;
    bus.btn_user_raw  = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce_reject();
    test_bounce_settle();
    test_simultaneous();
    test_reset_mid_count();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
